instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle decode/execute core. It owns the fetch PC, issues word requests to instruction memory over a req/ack handshake, and buffers returned instructions in a small prefetch queue. The queue is drained by the core through a valid/ready handshake. A branch/jump redirect from the core flushes the queue and restarts fetch at the new target.

---
 rtl/instr_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the word PC, fetches over req/ack into a DEPTH-entry prefetch queue, drains to the core via valid/ready.
// An ack is visible at the head one cycle later; a full queue parks fetch in HOLD until the core pops.
module instr_fetch_unit #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [31:0]              startPC,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     pc;
    logic [31:0]     pc_nxt;
    logic [31:0]     pend_pc;
    logic [31:0]     pend_pc_nxt;

    logic [31:0]     q_instr [DEPTH];
    logic [31:0]     q_pc    [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    logic            push;
    logic            pop;
    logic            flush;

    // Redirect kills both the push of in-flight data and any pop of wrong-path work.
    assign flush = redirect;
    assign push  = (state == REQ) && imem_ack && !redirect;
    assign pop   = (count != '0) && instr_ready && !redirect;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pend_pc_nxt = pend_pc;
        case (state)
            BOOT: begin
                pc_nxt    = redirect ? redirect_pc : startPC;
                state_nxt = REQ;
            end
            REQ: begin
                if (redirect) begin
                    if (imem_ack) begin
                        pc_nxt    = redirect_pc;
                        state_nxt = REQ;
                    end else begin
                        pend_pc_nxt = redirect_pc;
                        state_nxt   = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_nxt    = pc + 32'd1;
                    state_nxt = (count_nxt < FULL) ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = REQ;
                end else if (count_nxt < FULL) begin
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                // The old request must complete before the target can be issued; latest redirect wins.
                if (redirect) begin
                    pend_pc_nxt = redirect_pc;
                end
                if (imem_ack) begin
                    pc_nxt    = redirect ? redirect_pc : pend_pc;
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= BOOT;
            pc      <= '0;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // Storage is cleared on reset so the head outputs are defined while the queue is empty.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= pc;
        end
    end

    assign imem_req    = (state == REQ) || (state == DRAIN);
    assign imem_addr   = pc;
    assign instr_valid = (count != '0);
    assign instr       = q_instr[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];
    assign q_count     = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, backpressure, redirects, wrap and async reset.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] startPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  q_count;

    int compares;
    int fails;
    int acks;
    logic mem_en;

    instr_fetch_unit #(.DEPTH(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .startPC     (startPC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .q_count     (q_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents as a function of word address.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Zero-wait memory: acks whatever is requested in the current cycle when enabled.
    task automatic mem_drive();
        imem_ack   = mem_en && imem_req;
        imem_rdata = (mem_en && imem_req) ? mdata(imem_addr) : 32'h0;
    endtask

    task automatic tick();
        if (imem_ack && imem_req) acks++;
        @(posedge CLK);
        #1;
        mem_drive();
    endtask

    task automatic do_reset(input logic [31:0] spc);
        RESET       = 1'b1;
        mem_en      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        startPC     = spc;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        mem_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; startPC = 32'h10;
        tick();
        tick();
        compares++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
        compares++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
        compares++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
        compares++; if (instr !== 32'h0) begin fails++; $display("FAIL rst_instr got=%0h exp=0", instr); end
        compares++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_instr_pc got=%0h exp=0", instr_pc); end
        compares++; if (q_count !== 3'd0) begin fails++; $display("FAIL rst_count got=%0h exp=0", q_count); end
    endtask

    task automatic test_boot();
        do_reset(32'h10);
        instr_ready = 1'b1;
        mem_en = 1'b1;
        compares++; if (imem_req !== 1'b0) begin fails++; $display("FAIL boot_cycle_req got=%0h exp=0", imem_req); end
        tick();
        compares++; if (imem_req !== 1'b1) begin fails++; $display("FAIL boot_first_req got=%0h exp=1", imem_req); end
        compares++; if (imem_addr !== 32'h10) begin fails++; $display("FAIL boot_first_addr got=%0h exp=10", imem_addr); end
        compares++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL boot_first_valid got=%0h exp=0", instr_valid); end
        for (int k = 0; k < 4; k++) begin
            tick();
            compares++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL boot_valid[%0d] got=%0h exp=1", k, instr_valid); end
            compares++; if (instr_pc !== 32'h10 + k) begin fails++; $display("FAIL boot_pc[%0d] got=%0h exp=%0h", k, instr_pc, 32'h10 + k); end
            compares++; if (instr !== mdata(32'h10 + k)) begin fails++; $display("FAIL boot_instr[%0d] got=%0h exp=%0h", k, instr, mdata(32'h10 + k)); end
            compares++; if (imem_addr !== 32'h11 + k) begin fails++; $display("FAIL boot_addr[%0d] got=%0h exp=%0h", k, imem_addr, 32'h11 + k); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(32'h10);
        mem_en = 1'b1;
        acks = 0;
        repeat (8) tick();
        compares++; if (acks !== 4) begin fails++; $display("FAIL bp_acks got=%0d exp=4", acks); end
        compares++; if (q_count !== 3'd4) begin fails++; $display("FAIL bp_count got=%0d exp=4", q_count); end
        compares++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_hold_req got=%0h exp=0", imem_req); end
        compares++; if (imem_addr !== 32'h14) begin fails++; $display("FAIL bp_hold_pc got=%0h exp=14", imem_addr); end
        compares++; if (instr_pc !== 32'h10) begin fails++; $display("FAIL bp_head got=%0h exp=10", instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        compares++; if (imem_req !== 1'b1) begin fails++; $display("FAIL bp_resume_req got=%0h exp=1", imem_req); end
        compares++; if (imem_addr !== 32'h14) begin fails++; $display("FAIL bp_resume_addr got=%0h exp=14", imem_addr); end
        compares++; if (q_count !== 3'd3) begin fails++; $display("FAIL bp_resume_count got=%0d exp=3", q_count); end
        compares++; if (instr_pc !== 32'h11) begin fails++; $display("FAIL bp_resume_head got=%0h exp=11", instr_pc); end
        tick();
        compares++; if (q_count !== 3'd4) begin fails++; $display("FAIL bp_refull_count got=%0d exp=4", q_count); end
        compares++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_refull_req got=%0h exp=0", imem_req); end
    endtask

    task automatic test_redirect_hold();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        compares++; if (q_count !== 3'd0) begin fails++; $display("FAIL rh_count got=%0d exp=0", q_count); end
        compares++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rh_valid got=%0h exp=0", instr_valid); end
        compares++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rh_req got=%0h exp=1", imem_req); end
        compares++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL rh_addr got=%0h exp=40", imem_addr); end
        instr_ready = 1'b1;
        tick();
        compares++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL rh_data_valid got=%0h exp=1", instr_valid); end
        compares++; if (instr_pc !== 32'h40) begin fails++; $display("FAIL rh_data_pc got=%0h exp=40", instr_pc); end
        compares++; if (instr !== mdata(32'h40)) begin fails++; $display("FAIL rh_data got=%0h exp=%0h", instr, mdata(32'h40)); end
        compares++; if (imem_addr !== 32'h41) begin fails++; $display("FAIL rh_next_addr got=%0h exp=41", imem_addr); end
    endtask

    task automatic test_redirect_drain();
        do_reset(32'h10);
        instr_ready = 1'b1;
        mem_en = 1'b1;
        tick();
        tick();
        mem_en = 1'b0;
        tick();
        compares++; if (imem_addr !== 32'h12 || imem_req !== 1'b1) begin fails++; $display("FAIL rd_pending got=%0h/%0h exp=12/1", imem_addr, imem_req); end
        compares++; if (instr_pc !== 32'h11) begin fails++; $display("FAIL rd_head got=%0h exp=11", instr_pc); end
        redirect = 1'b1;
        redirect_pc = 32'h80;
        tick();
        compares++; if (q_count !== 3'd0 || instr_valid !== 1'b0) begin fails++; $display("FAIL rd_flush got=%0d/%0h exp=0/0", q_count, instr_valid); end
        compares++; if (imem_req !== 1'b1 || imem_addr !== 32'h12) begin fails++; $display("FAIL rd_hold_old got=%0h/%0h exp=1/12", imem_req, imem_addr); end
        redirect_pc = 32'h90;
        tick();
        redirect = 1'b0;
        compares++; if (imem_req !== 1'b1 || imem_addr !== 32'h12) begin fails++; $display("FAIL rd_hold_old2 got=%0h/%0h exp=1/12", imem_req, imem_addr); end
        compares++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rd_valid2 got=%0h exp=0", instr_valid); end
        mem_en = 1'b1;
        mem_drive();
        tick();
        compares++; if (instr_valid !== 1'b0 || q_count !== 3'd0) begin fails++; $display("FAIL rd_discard got=%0h/%0d exp=0/0", instr_valid, q_count); end
        compares++; if (imem_req !== 1'b1 || imem_addr !== 32'h90) begin fails++; $display("FAIL rd_target got=%0h/%0h exp=1/90", imem_req, imem_addr); end
        tick();
        compares++; if (instr_valid !== 1'b1 || instr_pc !== 32'h90) begin fails++; $display("FAIL rd_first got=%0h/%0h exp=1/90", instr_valid, instr_pc); end
        compares++; if (instr !== mdata(32'h90)) begin fails++; $display("FAIL rd_first_data got=%0h exp=%0h", instr, mdata(32'h90)); end
    endtask

    task automatic test_redirect_ack();
        do_reset(32'h30);
        mem_en = 1'b1;
        tick();
        tick();
        compares++; if (q_count !== 3'd1 || imem_addr !== 32'h31) begin fails++; $display("FAIL ra_setup got=%0d/%0h exp=1/31", q_count, imem_addr); end
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        compares++; if (q_count !== 3'd0 || instr_valid !== 1'b0) begin fails++; $display("FAIL ra_flush got=%0d/%0h exp=0/0", q_count, instr_valid); end
        compares++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL ra_target got=%0h/%0h exp=1/200", imem_req, imem_addr); end
        tick();
        compares++; if (q_count !== 3'd1 || instr_pc !== 32'h200) begin fails++; $display("FAIL ra_first got=%0d/%0h exp=1/200", q_count, instr_pc); end
        compares++; if (instr !== mdata(32'h200)) begin fails++; $display("FAIL ra_first_data got=%0h exp=%0h", instr, mdata(32'h200)); end
    endtask

    task automatic test_wrap();
        do_reset(32'hFFFF_FFFF);
        instr_ready = 1'b1;
        mem_en = 1'b1;
        tick();
        compares++; if (imem_addr !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_addr0 got=%0h exp=ffffffff", imem_addr); end
        tick();
        compares++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr1 got=%0h exp=0", imem_addr); end
        compares++; if (instr_pc !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_pc0 got=%0h exp=ffffffff", instr_pc); end
        tick();
        compares++; if (instr_pc !== 32'h0 || instr !== mdata(32'h0)) begin fails++; $display("FAIL wrap_pc1 got=%0h/%0h exp=0/%0h", instr_pc, instr, mdata(32'h0)); end
        compares++; if (imem_addr !== 32'h1) begin fails++; $display("FAIL wrap_addr2 got=%0h exp=1", imem_addr); end
    endtask

    task automatic test_async_reset();
        do_reset(32'h10);
        mem_en = 1'b1;
        repeat (4) tick();
        compares++; if (q_count !== 3'd3 || imem_req !== 1'b1) begin fails++; $display("FAIL ar_setup got=%0d/%0h exp=3/1", q_count, imem_req); end
        #2;
        RESET = 1'b1;
        #1;
        compares++; if (imem_req !== 1'b0) begin fails++; $display("FAIL ar_req got=%0h exp=0", imem_req); end
        compares++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got=%0h exp=0", instr_valid); end
        compares++; if (q_count !== 3'd0) begin fails++; $display("FAIL ar_count got=%0d exp=0", q_count); end
        compares++; if (imem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL ar_data got=%0h/%0h/%0h exp=0/0/0", imem_addr, instr, instr_pc); end
        mem_en = 1'b0;
        imem_ack = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        compares = 0;
        fails = 0;
        acks = 0;
        mem_en = 1'b0;
        test_reset();
        test_boot();
        test_backpressure();
        test_redirect_hold();
        test_redirect_drain();
        test_redirect_ack();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
